// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : aes_key_sched_ctrl                                         |
// | Description : Iterative AES key-schedule controller. Drives an external  |
// |               KeyExpansion round stage once per round, stores each round |
// |               key in an internal table and serves it on a registered     |
// |               read port.                                                 |
// | Options     : KSC_AES256_EN - adds AES-256 support (15-entry table,      |
// |               odd/even flip sequencing, honours key_len).                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module aes_key_sched_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         key_len,
  input  logic [255:0] cipher_key,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         rk_valid,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic [127:0] dp_key,
  output logic [127:0] dp_prev_key,
  output logic         dp_key_len,
  output logic         dp_flip,
  output logic [3:0]   dp_rnum,
  output logic         dp_valid_in,
  input  logic         dp_valid_out,
  input  logic [127:0] dp_out_key
);

`ifdef KSC_AES256_EN
  localparam int c_DEPTH = 15;
`else
  localparam int c_DEPTH = 11;
`endif
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       r_state;
  logic [3:0]   r_idx;
  logic         r_key_len;
  logic [15:0]  r_wait_cnt;
  logic [127:0] r_rk [0:c_DEPTH-1];

  logic         w_key_len;
  logic         w_accept;
  logic         w_capture;
  logic [3:0]   w_last_idx;
  logic [4:0]   w_num_keys;

`ifdef KSC_AES256_EN
  assign w_key_len = key_len;
`else
  // Without AES-256 support the key length and lower key half are unused.
  assign w_key_len = 1'b0;
  logic w_unused;
  assign w_unused = ^{key_len, cipher_key[127:0]};
`endif

  assign w_accept   = (r_state == S_IDLE) && ready && start;
  assign w_capture  = (r_state == S_WAIT) && dp_valid_out;
  assign w_last_idx = r_key_len ? 4'd14 : 4'd10;
  assign w_num_keys = r_key_len ? 5'd15 : 5'd11;

  // Control FSM: handshake, round sequencing, stage drive and timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_key_len   <= 1'b0;
      r_wait_cnt  <= 16'd0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rk_valid    <= 1'b0;
      dp_key      <= '0;
      dp_prev_key <= '0;
      dp_key_len  <= 1'b0;
      dp_flip     <= 1'b0;
      dp_rnum     <= 4'd0;
      dp_valid_in <= 1'b0;
    end else begin
      done        <= 1'b0;
      dp_valid_in <= 1'b0;
      case (r_state)
        S_IDLE: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          if (w_accept) begin
            ready       <= 1'b0;
            busy        <= 1'b1;
            err         <= 1'b0;
            rk_valid    <= 1'b0;
            r_key_len   <= w_key_len;
            dp_key_len  <= w_key_len;
            r_wait_cnt  <= 16'd0;
            // First round always uses flip=1, rnum=0 in both key sizes.
            dp_prev_key <= cipher_key[255:128];
            dp_flip     <= 1'b1;
            dp_rnum     <= 4'd0;
            dp_valid_in <= 1'b1;
            r_state     <= S_ISSUE;
`ifdef KSC_AES256_EN
            if (w_key_len) begin
              r_idx  <= 4'd2;
              dp_key <= cipher_key[127:0];
            end else begin
              r_idx  <= 4'd1;
              dp_key <= cipher_key[255:128];
            end
`else
            r_idx  <= 4'd1;
            dp_key <= cipher_key[255:128];
`endif
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (dp_valid_out) begin
            r_idx      <= r_idx + 4'd1;
            r_wait_cnt <= 16'd0;
            if (r_idx == w_last_idx) begin
              r_state <= S_DONE;
            end else begin
              // The key just returned is RK[idx]; it becomes the next key.
              r_state     <= S_ISSUE;
              dp_valid_in <= 1'b1;
              dp_key      <= dp_out_key;
`ifdef KSC_AES256_EN
              if (r_key_len) begin
                // Next idx is even (flip round) exactly when idx is odd.
                dp_prev_key <= dp_key;
                dp_flip     <= r_idx[0];
                dp_rnum     <= {1'b0, r_idx[3:1]};
              end else begin
                dp_prev_key <= dp_out_key;
                dp_flip     <= 1'b1;
                dp_rnum     <= r_idx;
              end
`else
              dp_prev_key <= dp_out_key;
              dp_flip     <= 1'b1;
              dp_rnum     <= r_idx;
`endif
            end
          end else if (r_wait_cnt == c_TO_LAST) begin
            err      <= 1'b1;
            rk_valid <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        S_DONE: begin
          done     <= 1'b1;
          rk_valid <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Round-key table: cipher key words on acceptance, stage results in WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < c_DEPTH; i++) r_rk[i] <= '0;
    end else if (w_accept) begin
      r_rk[0] <= cipher_key[255:128];
`ifdef KSC_AES256_EN
      if (w_key_len) r_rk[1] <= cipher_key[127:0];
`endif
    end else if (w_capture) begin
      r_rk[r_idx] <= dp_out_key;
    end
  end

  // Registered read port; addresses beyond the active key count read zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rk_data <= '0;
    end else if ({1'b0, rk_addr} < w_num_keys) begin
      rk_data <= r_rk[rk_addr];
    end else begin
      rk_data <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_aes_key_sched_ctrl                                      |
// | Description : Self-checking bench for aes_key_sched_ctrl with a          |
// |               behavioural KeyExpansion stage and a FIPS-197 word-level   |
// |               reference expansion. AES-256 cases need KSC_AES256_EN.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_aes_key_sched_ctrl;

  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         key_len;
  logic [255:0] cipher_key;
  logic         ready, busy, done, err, rk_valid;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic [127:0] dp_key, dp_prev_key;
  logic         dp_key_len, dp_flip;
  logic [3:0]   dp_rnum;
  logic         dp_valid_in;
  logic         dp_valid_out = 1'b0;
  logic [127:0] dp_out_key = '0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   sbox [256];
  logic [127:0] ref_rk [15];
  logic         stage_en;
  logic [5:0]   iss_log [1024];
  int           iss_n = 0;

  aes_key_sched_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .key_len(key_len),
    .cipher_key(cipher_key), .ready(ready), .busy(busy), .done(done),
    .err(err), .rk_valid(rk_valid), .rk_addr(rk_addr), .rk_data(rk_data),
    .dp_key(dp_key), .dp_prev_key(dp_prev_key), .dp_key_len(dp_key_len),
    .dp_flip(dp_flip), .dp_rnum(dp_rnum), .dp_valid_in(dp_valid_in),
    .dp_valid_out(dp_valid_out), .dp_out_key(dp_out_key)
  );

  always #5 clk = ~clk;

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] p, a;
    p = 8'h00;
    a = a_in;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < j; i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [31:0] rotw(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Behavioural KeyExpansion round stage.
  function automatic logic [127:0] stage_f(input logic [127:0] k, input logic [127:0] prev,
                                           input logic flip, input logic [3:0] rnum);
    logic [31:0] t, w0, w1, w2, w3;
    t = k[31:0];
    if (flip) t = subw(rotw(t)) ^ {rcon(int'(rnum) + 1), 24'h0};
    else      t = subw(t);
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // FIPS-197 word-oriented key expansion into ref_rk (unused entries zero).
  task automatic ref_expand(input logic [255:0] k, input logic kl);
    logic [31:0] w [60];
    int nk, nr, tot;
    nk  = kl ? 8 : 4;
    nr  = kl ? 14 : 10;
    tot = 4 * (nr + 1);
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < tot; i++) begin
      logic [31:0] t;
      t = w[i-1];
      if (i % nk == 0)               t = subw(rotw(t)) ^ {rcon(i / nk), 24'h0};
      else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      ref_rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Stage stub: one-cycle latency, logs each issue for sequencing checks.
  always @(posedge clk) begin
    dp_valid_out <= 1'b0;
    if (stage_en && dp_valid_in) begin
      dp_out_key   <= stage_f(dp_key, dp_prev_key, dp_flip, dp_rnum);
      dp_valid_out <= 1'b1;
      if (iss_n < 1024) iss_log[iss_n] <= {dp_key_len, dp_flip, dp_rnum};
      iss_n <= iss_n + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 100) begin tick(); n++; end
    if (!ready) chk("ready_wait", {127'b0, ready}, 128'd1);
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic eff_len(input logic kl);
`ifdef KSC_AES256_EN
    return kl;
`else
    return 1'b0;
`endif
  endfunction

  // Full expansion: latency, done/ready/rk_valid timing and stage sequencing.
  task automatic run_exp(input logic [255:0] k, input logic kl, output int lat);
    int base, nround, e;
    logic el;
    el = eff_len(kl);
    wait_ready();
    base = iss_n;
    cipher_key = k; key_len = kl; start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", {127'b0, busy}, 128'd1);
    chk("accept_err_clear", {127'b0, err}, 128'd0);
    lat = 0;
    while (!done && lat < 200) begin tick(); lat++; end
    if (!done) lat = -1;
    chk("done_latency", 128'(lat), el ? 128'd27 : 128'd21);
    chk("done_rk_valid", {127'b0, rk_valid}, 128'd1);
    chk("done_ready_low", {127'b0, ready}, 128'd0);
    tick();
    chk("done_one_cycle", {127'b0, done}, 128'd0);
    chk("ready_after_done", {127'b0, ready}, 128'd1);
    nround = el ? 13 : 10;
    chk("issue_count", 128'(iss_n - base), 128'(nround));
    for (int i = 0; i < nround && base + i < 1024; i++) begin
      logic [5:0] ent;
      int idx;
      ent = iss_log[base + i];
      idx = i + (el ? 2 : 1);
      chk("dp_key_len", {127'b0, ent[5]}, {127'b0, el});
      if (el && (idx % 2 == 1)) begin
        chk("dp_flip_odd", {127'b0, ent[4]}, 128'd0);
      end else begin
        e = el ? idx / 2 - 1 : idx - 1;
        chk("dp_flip", {127'b0, ent[4]}, 128'd1);
        chk("dp_rnum", {124'b0, ent[3:0]}, 128'(e));
      end
    end
  endtask

  task automatic read_all(input logic kl);
    int nk;
    nk = eff_len(kl) ? 15 : 11;
    for (int a = 0; a < 16; a++) begin
      rk_addr = 4'(a);
      tick();
      chk($sformatf("rk[%0d]", a), rk_data, (a < nk) ? ref_rk[a] : 128'h0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},    {127'b0, ready},       128'd1);
    chk({tag, "_busy"},     {127'b0, busy},        128'd0);
    chk({tag, "_done"},     {127'b0, done},        128'd0);
    chk({tag, "_err"},      {127'b0, err},         128'd0);
    chk({tag, "_rk_valid"}, {127'b0, rk_valid},    128'd0);
    chk({tag, "_vin"},      {127'b0, dp_valid_in}, 128'd0);
    chk({tag, "_flip"},     {127'b0, dp_flip},     128'd0);
    chk({tag, "_klen"},     {127'b0, dp_key_len},  128'd0);
    chk({tag, "_rnum"},     {124'b0, dp_rnum},     128'd0);
    chk({tag, "_key"},      dp_key,                128'd0);
    chk({tag, "_prev"},     dp_prev_key,           128'd0);
    chk({tag, "_rk_data"},  rk_data,               128'd0);
  endtask

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
  } rd_vec_t;

  // ---------------- main sequence ----------------
  initial begin
    rd_vec_t      tbl [8];
    logic [255:0] k128, kA, kB;
    int           lat, n;

    tbl[0] = '{4'd0,  128'h000102030405060708090a0b0c0d0e0f};
    tbl[1] = '{4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    tbl[2] = '{4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    tbl[3] = '{4'd11, 128'h0};
    tbl[4] = '{4'd12, 128'h0};
    tbl[5] = '{4'd13, 128'h0};
    tbl[6] = '{4'd14, 128'h0};
    tbl[7] = '{4'd15, 128'h0};

    init_sbox();
    stage_en = 1'b1;
    reset = 1'b0; start = 1'b1; key_len = 1'b0; cipher_key = '1; rk_addr = 4'd0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    start = 1'b0;
    reset = 1'b1;
    tick();
    chk("post_reset_ready", {127'b0, ready}, 128'd1);

    // FIPS-197 AES-128 vector, table-driven readback.
    k128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    run_exp(k128, 1'b0, lat);
    for (int i = 0; i < 8; i++) begin
      rk_addr = tbl[i].addr;
      tick();
      chk($sformatf("fips128_rd%0d", tbl[i].addr), rk_data, tbl[i].exp);
    end

    // Read port has one cycle of latency.
    rk_addr = 4'd0;
    tick();
    rk_addr = 4'd10;
    #1;
    chk("rd_latency_old", rk_data, tbl[0].exp);
    tick();
    chk("rd_latency_new", rk_data, tbl[2].exp);

`ifdef KSC_AES256_EN
    // FIPS-197 AES-256 vector.
    kA = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    run_exp(kA, 1'b1, lat);
    rk_addr = 4'd14;
    tick();
    chk("fips256_rk14", rk_data, 128'h24fc79ccbf0979e9371ac23c6d68de36);
`endif

    // Randomised keys against the reference expansion.
    for (int t = 0; t < 6; t++) begin
      logic kl;
      kA = rand256();
      kl = 1'($urandom_range(0, 1));
      ref_expand(kA, eff_len(kl));
      run_exp(kA, kl, lat);
      read_all(kl);
    end

    // Busy handshake: a second start mid-expansion is ignored.
    kA = rand256();
    kB = rand256();
    ref_expand(kA, 1'b0);
    wait_ready();
    cipher_key = kA; key_len = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    cipher_key = kB; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("busy_ready_low", {127'b0, ready}, 128'd0);
    end
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    chk("busy_done_seen", {127'b0, done}, 128'd1);
    rk_addr = 4'd10;
    tick();
    chk("busy_rk10", rk_data, ref_rk[10]);
    rk_addr = 4'd1;
    tick();
    chk("busy_rk1", rk_data, ref_rk[1]);

    // Timeout: stage never answers.
    stage_en = 1'b0;
    wait_ready();
    cipher_key = rand256(); key_len = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!err && n < 100) begin tick(); n++; end
    chk("timeout_cycles", 128'(n), 128'(1 + TO));
    chk("timeout_rk_valid", {127'b0, rk_valid}, 128'd0);
    tick();
    chk("timeout_ready", {127'b0, ready}, 128'd1);
    chk("timeout_err_sticky", {127'b0, err}, 128'd1);
    stage_en = 1'b1;
    kA = rand256();
    ref_expand(kA, 1'b0);
    run_exp(kA, 1'b0, lat);
    rk_addr = 4'd10;
    tick();
    chk("after_timeout_rk10", rk_data, ref_rk[10]);

    // Reset during round 5, then a fresh expansion.
    rk_addr = 4'd1;
    kA = rand256();
    ref_expand(kA, 1'b0);
    wait_ready();
    cipher_key = kA; key_len = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("midreset_busy_before", {127'b0, busy}, 128'd1);
    reset = 1'b0;
    tick();
    chk_reset_outputs("midreset");
    reset = 1'b1;
    run_exp(kA, 1'b0, lat);
    rk_addr = 4'd10;
    tick();
    chk("midreset_rk10", rk_data, ref_rk[10]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Iterative key-schedule controller that sequences a single external `KeyExpansion` round stage to build the complete AES round-key table. It accepts a cipher key through a start/ready handshake and drives the stage once per round with the correct `key`, `prev_key`, `flip`, `rnum` and `keyLen`. It stores each returned round key in an internal table and exposes that table to the cipher core through a registered read port. It sits between the key-load interface and the encrypt/decrypt round pipeline.

## Interface
- `TIMEOUT`, default 15: maximum cycles spent in WAIT for `dp_valid_out` before the controller aborts.
- `clk` in 1: sole clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: request expansion; accepted only when `ready`=1.
- `key_len` in 1: 0 = AES-128, 1 = AES-256; sampled on acceptance.
- `cipher_key` in 256: AES-128 uses `[255:128]`; sampled on acceptance.
- `ready` out 1: controller is in IDLE.
- `busy` out 1: expansion in progress.
- `done` out 1: one-cycle pulse when the table is complete.
- `err` out 1: sticky timeout flag; cleared by the next accepted `start`.
- `rk_valid` out 1: table complete and consistent.
- `rk_addr` in 4: round-key index.
- `rk_data` out 128: registered read data; 0 if `rk_addr` ≥ NUM_KEYS.
- `dp_key`, `dp_prev_key` out 128: stage `key` / `prev_key` inputs.
- `dp_key_len`, `dp_flip` out 1: stage `keyLen` / `flip`.
- `dp_rnum` out 4: stage `rnum`.
- `dp_valid_in` out 1: stage `validIn`.
- `dp_valid_out` in 1, `dp_out_key` in 128: stage outputs.

## Operation
- NUM_KEYS is 11 for AES-128 and 15 for AES-256. The round-key table RK[0..14] is 128 bits per entry.
- States are IDLE, ISSUE, WAIT and DONE.
- **IDLE → ISSUE** on `start`=1:
  - RK[0] = `cipher_key[255:128]`.
  - For AES-256 only, RK[1] = `cipher_key[127:0]`.
  - `idx` = 1 (AES-128) or 2 (AES-256).
  - Clear `rk_valid` and `err`; latch `key_len`.
- **ISSUE** lasts one cycle with `dp_valid_in`=1, then moves to WAIT.
- **Stage drive for AES-128:** `dp_key` = RK[idx-1], `dp_prev_key` = RK[idx-1], `dp_flip`=1, `dp_rnum` = idx-1.
- **Stage drive for AES-256:**
  - `dp_prev_key` = RK[idx-2], `dp_key` = RK[idx-1].
  - idx even: `dp_flip`=1, `dp_rnum` = idx/2-1.
  - idx odd: `dp_flip`=0.
  - `dp_rnum` values are don't-care on odd idx.
- The `dp_*` outputs are registered and held stable through ISSUE and WAIT.
- **WAIT**, on `dp_valid_out`=1:
  - RK[idx] = `dp_out_key`; `idx`++.
  - If `idx` was NUM_KEYS-1, go to DONE; otherwise go to ISSUE.
- **WAIT timeout:** after `TIMEOUT` cycles without `dp_valid_out`, set `err`=1 and return to IDLE with `rk_valid`=0.
- **DONE:** `done`=1 and `rk_valid`=1 for one cycle, then IDLE. `rk_valid` stays 1 until the next accepted `start`.
- `dp_valid_out` is ignored outside WAIT.
- `start` is ignored while `busy`=1.
- The read port is live in every state. Entries not yet written read their old or reset contents.

## Timing
- **Reset values** (while `reset`=0 at an edge):
  - State = IDLE; `ready`=1.
  - `busy`, `done`, `err`, `rk_valid`, `dp_valid_in`, `dp_flip`, `dp_key_len` = 0.
  - `dp_rnum` = 0, `dp_key` = 0, `dp_prev_key` = 0.
  - All RK entries = 0; `rk_data` = 0.
- **Reset mid-expansion** discards progress. Same-cycle `start` is ignored.
- **Per-round cost** is 1 + L cycles, where L is the stage latency (nominal L=1, so 2 cycles).
- **Expansion latency** from the `start` edge to the `done` pulse, with L=1:
  - AES-128: 1 + 10×2 = 21 cycles.
  - AES-256: 1 + 13×2 = 27 cycles.
- `ready` returns the cycle after `done`.
- `rk_data` reflects `rk_addr` one cycle later. A write and a read of the same entry in the same cycle return the old data.

## Configuration
- `KSC_AES256_EN` defined:
  - `key_len` is honoured.
  - The table has 15 entries.
  - The odd/even `flip` sequencing for AES-256 is compiled in.
- `KSC_AES256_EN` undefined:
  - `key_len` is ignored and treated as 0; `dp_key_len` is tied to 0.
  - The table has 11 entries; `rk_data` = 0 for `rk_addr` ≥ 11.
  - AES-256 sequencing logic is removed.

## Test plan
- **AES-128 expansion (FIPS-197):** `start` with key 000102030405060708090a0b0c0d0e0f.
  - `done` arrives at cycle 21.
  - RK[1] = d6aa74fdd2af72fadaa678f1d6ab76fe.
  - RK[10] = 13111d7fe3944a17f307a78b4d2b30c5.
  - `rk_valid`=1.
- **AES-256 expansion** (`KSC_AES256_EN` defined): `start` with key 000102…1f and `key_len`=1.
  - `done` arrives at cycle 27.
  - RK[14] = 24fc79ccbf0979e9371ac23c6d68de36.
  - `dp_flip` alternates 0/1 from idx 2, and `dp_rnum` runs 0..6 on the even idx values.
- **Busy handshake:** re-assert `start` with a different key mid-expansion.
  - It is ignored; `ready`=0 throughout.
  - The final table matches the first key.
- **Timeout:** stub the stage so it never raises `dp_valid_out`.
  - `err`=1 after `TIMEOUT` WAIT cycles; controller returns to IDLE with `rk_valid`=0.
  - The next `start` clears `err`.
- **Reset mid-operation:** drive `reset`=0 during round 5.
  - Next cycle: all outputs, including `rk_data`, are at reset values.
  - A fresh `start` then reproduces the correct RK[10].
- **Read port:** read `rk_addr`=15 → 0. Without `KSC_AES256_EN`, read `rk_addr`=12 → 0. Read data appears one cycle after the address.
